// File: rtl/apb_requester.sv
// APB initiator: turns single CPU load/store requests into APB setup/access
// transfers, bounding each ACCESS phase with a timeout and pulsing APB_perr on errors.
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wstb,
  input  logic                  req_write,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr,
  output logic                  APB_perr
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        done, tmo_hit;

  assign req_ready = (state == IDLE);

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE:   if (req_valid) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        // pready takes priority over a timeout firing in the same cycle
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (TMO_EN && cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pstb      <= 4'h0;
      paddr     <= '0;
      pdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      APB_perr  <= 1'b0;
      cnt       <= 16'h0;
    end else begin
      rsp_valid <= 1'b0;
      APB_perr  <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          paddr   <= req_addr;
          pdata   <= req_wdata;
          pwrite  <= req_write;
          pstb    <= req_write ? req_wstb : 4'h0;
          psel    <= 1'b1;
          penable <= 1'b0;
        end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= 16'h0;
        end
        ACCESS: begin
          if (done) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= perr;
            APB_perr  <= perr;
          end else if (tmo_hit) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            APB_perr  <= 1'b1;
          end else if (cnt != 16'hFFFF) begin
            // saturates only when the timeout is disabled
            cnt <= cnt + 16'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed table, random transfers against a
// transfer-level reference model, and reset-abort / back-to-back sequences.
module tb_apb_requester;

  localparam int TMO = 16;

  logic        pclk, rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pdata, prdata;
  logic        psel, penable, pwrite, pready, perr, APB_perr;
  logic [3:0]  pstb;

  int nchk = 0;
  int nerr = 0;

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstb(req_wstb), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstb(pstb), .pready(pready), .perr(perr), .APB_perr(APB_perr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // waits = ACCESS cycles with pready low before the completer answers
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic        write;
    int          waits;
    logic        perr;
    logic [31:0] prdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transfer-level model: a reply arriving within TMO ACCESS cycles completes
  // normally 3+waits cycles after acceptance; otherwise abort at TMO+2.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    bit tmo = (TMO != 0) && (t.waits >= TMO);
    r.lat   = tmo ? TMO + 2 : t.waits + 3;
    r.err   = tmo | t.perr;
    r.rdata = (tmo || t.write) ? 32'h0 : t.prdata;
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the rsp_valid cycle.
  task automatic do_txn(input txn_t t);
    logic [3:0] exp_stb = t.write ? t.wstb : 4'h0;
    chk({t.name, ".req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_addr = t.addr; req_wdata = t.wdata;
    req_wstb = t.wstb; req_write = t.write;
    for (int k = 1; k <= t.lat; k++) begin
      @(negedge pclk);
      // request stays asserted with junk: it must be ignored outside IDLE
      req_addr = $urandom; req_wdata = $urandom;
      req_wstb = 4'($urandom); req_write = 1'($urandom);
      chk({t.name, ".paddr"},  paddr, t.addr);
      chk({t.name, ".pdata"},  pdata, t.wdata);
      chk({t.name, ".pwrite"}, {31'h0, pwrite}, {31'h0, t.write});
      chk({t.name, ".pstb"},   {28'h0, pstb}, {28'h0, exp_stb});
      if (k < t.lat) begin
        chk({t.name, ".psel"},      {31'h0, psel}, 32'h1);
        chk({t.name, ".penable"},   {31'h0, penable}, (k >= 2) ? 32'h1 : 32'h0);
        chk({t.name, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({t.name, ".APB_perr"},  {31'h0, APB_perr}, 32'h0);
      end else begin
        chk({t.name, ".psel_end"},  {31'h0, psel}, 32'h0);
        chk({t.name, ".penable_end"}, {31'h0, penable}, 32'h0);
        chk({t.name, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({t.name, ".rsp_err"},   {31'h0, rsp_err}, {31'h0, t.err});
        chk({t.name, ".rsp_rdata"}, rsp_rdata, t.rdata);
        chk({t.name, ".APB_perr"},  {31'h0, APB_perr}, {31'h0, t.err});
      end
      pready = (k < t.lat) && (k == t.waits + 2);
      prdata = pready ? t.prdata : $urandom;
      perr   = pready ? t.perr : 1'($urandom);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      pready = 1'($urandom); perr = 1'($urandom); prdata = $urandom;
      @(negedge pclk);
      chk("idle.psel",      {31'h0, psel}, 32'h0);
      chk("idle.rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("idle.APB_perr",  {31'h0, APB_perr}, 32'h0);
      chk("idle.req_ready", {31'h0, req_ready}, 32'h1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  txn_t vec[7];
  txn_t t;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_wstb = 4'h0; req_write = 1'b0; prdata = 32'h0; pready = 1'b0; perr = 1'b0;

    vec[0] = '{"wr",       32'h2000_0004, 32'h3,         4'hF, 1'b1, 0,  1'b0, 32'h0,         3,  1'b0, 32'h0};
    vec[1] = '{"rd",       32'h2000_0000, 32'h1234_5678, 4'hF, 1'b0, 1,  1'b0, 32'h2,         4,  1'b0, 32'h2};
    vec[2] = '{"rd_perr",  32'h2000_0008, 32'h0,         4'h3, 1'b0, 0,  1'b1, 32'hDEAD_BEEF, 3,  1'b1, 32'hDEAD_BEEF};
    vec[3] = '{"wr_tmo",   32'h3000_0010, 32'hA5A5_A5A5, 4'hC, 1'b1, 20, 1'b0, 32'h0,         18, 1'b1, 32'h0};
    vec[4] = '{"rd_edge",  32'h3000_0014, 32'h0,         4'hF, 1'b0, 15, 1'b0, 32'hCAFE_F00D, 18, 1'b0, 32'hCAFE_F00D};
    vec[5] = '{"rd_tmo",   32'h3000_0018, 32'h0,         4'hF, 1'b0, 16, 1'b0, 32'h1111_2222, 18, 1'b1, 32'h0};
    vec[6] = '{"wr_perr",  32'h2000_000C, 32'h55,        4'h5, 1'b1, 2,  1'b1, 32'h9999_9999, 5,  1'b1, 32'h0};

    repeat (2) @(negedge pclk);
    chk("rst.psel",      {31'h0, psel}, 32'h0);
    chk("rst.penable",   {31'h0, penable}, 32'h0);
    chk("rst.pwrite",    {31'h0, pwrite}, 32'h0);
    chk("rst.pstb",      {28'h0, pstb}, 32'h0);
    chk("rst.paddr",     paddr, 32'h0);
    chk("rst.pdata",     pdata, 32'h0);
    chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err",   {31'h0, rsp_err}, 32'h0);
    chk("rst.APB_perr",  {31'h0, APB_perr}, 32'h0);
    chk("rst.req_ready", {31'h0, req_ready}, 32'h1);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 7; i++) begin
      do_txn(vec[i]);
      idle(1);
    end

    // reset in ACCESS abandons the transfer
    req_valid = 1'b1; req_addr = 32'h4000_0000; req_wdata = 32'h77; req_wstb = 4'hF; req_write = 1'b1;
    pready = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    chk("rstacc.psel_pre",    {31'h0, psel}, 32'h1);
    chk("rstacc.penable_pre", {31'h0, penable}, 32'h1);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk("rstacc.psel",      {31'h0, psel}, 32'h0);
    chk("rstacc.penable",   {31'h0, penable}, 32'h0);
    chk("rstacc.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rstacc.paddr",     paddr, 32'h0);
    idle(3);

    // back-to-back: second request accepted in the first's rsp_valid cycle
    t = model('{"b2b_a", 32'h2000_0040, 32'h1, 4'h1, 1'b1, 0, 1'b0, 32'h0, 0, 1'b0, 32'h0});
    do_txn(t);
    t = model('{"b2b_b", 32'h2000_0044, 32'h2, 4'hF, 1'b0, 1, 1'b0, 32'h0BAD_CAFE, 0, 1'b0, 32'h0});
    do_txn(t);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      t.name   = "rnd";
      t.addr   = $urandom;
      t.wdata  = $urandom;
      t.wstb   = 4'($urandom);
      t.write  = 1'($urandom);
      t.waits  = $urandom_range(0, 20);
      t.perr   = ($urandom_range(0, 3) == 0);
      t.prdata = $urandom;
      do_txn(model(t));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
